rf_wb_arbiter: RTL and testbench

Write-port controller for the 32-entry GPR file. After reset it sequences a zero-clear of every entry. It then shares the single RF write port between two writeback requesters, EXU (req 0) and LSU (req 1), using round-robin arbitration. It also keeps a busy scoreboard that issue logic queries for RAW hazards. It sits between the WBU-side requesters and the register file's wdata/waddr/w_en inputs.

---
 rtl/rf_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// GPR write-port controller: post-reset zero-clear, round-robin EXU/LSU writeback, busy scoreboard.
// Optional perf counters (conflict_cnt, stall_cnt) built when RF_WB_ARB_PERF_EN is defined.
module rf_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wb0_valid,
    output logic                  wb0_ready,
    input  logic [ADDR_WIDTH-1:0] wb0_addr,
    input  logic [DATA_WIDTH-1:0] wb0_data,
    input  logic                  wb1_valid,
    output logic                  wb1_ready,
    input  logic [ADDR_WIDTH-1:0] wb1_addr,
    input  logic [DATA_WIDTH-1:0] wb1_data,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic [ADDR_WIDTH-1:0] ra_addr,
    input  logic [ADDR_WIDTH-1:0] rb_addr,
    output logic                  ra_busy,
    output logic                  rb_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  init_done
`ifdef RF_WB_ARB_PERF_EN
    ,
    output logic [31:0]           conflict_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int unsigned NREG = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_d;
    logic [NREG-1:0]         busy, busy_d;
    logic                    rr_last, rr_last_d;
    logic                    rf_wen_d;
    logic [ADDR_WIDTH-1:0]   rf_waddr_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_d;
    logic                    init_done_d;
    logic                    gnt0, gnt1, hs;
    logic [ADDR_WIDTH-1:0]   wb_addr;
    logic [DATA_WIDTH-1:0]   wb_data;

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            busy      <= '0;
            rr_last   <= 1'b1;
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_d;
            clr_cnt   <= clr_cnt_d;
            busy      <= busy_d;
            rr_last   <= rr_last_d;
            rf_wen    <= rf_wen_d;
            rf_waddr  <= rf_waddr_d;
            rf_wdata  <= rf_wdata_d;
            init_done <= init_done_d;
        end
    end

    // Next state, arbitration and scoreboard update
    always_comb begin
        state_d     = state;
        clr_cnt_d   = clr_cnt;
        busy_d      = busy;
        rr_last_d   = rr_last;
        rf_wen_d    = 1'b0;
        rf_waddr_d  = rf_waddr;
        rf_wdata_d  = rf_wdata;
        init_done_d = init_done;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        hs          = 1'b0;
        wb_addr     = wb0_addr;
        wb_data     = wb0_data;

        case (state)
            CLEAR: begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = clr_cnt;
                rf_wdata_d = '0;
                clr_cnt_d  = clr_cnt + ADDR_WIDTH'(1);
                if (clr_cnt == ADDR_WIDTH'(NREG - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                init_done_d = 1'b1;
                // On a tie the requester that did not win last gets the port
                gnt0 = wb0_valid && (!wb1_valid || rr_last);
                gnt1 = wb1_valid && (!wb0_valid || !rr_last);
                hs   = gnt0 || gnt1;
                if (gnt1) begin
                    wb_addr = wb1_addr;
                    wb_data = wb1_data;
                end
                if (hs) begin
                    rr_last_d         = gnt1;
                    rf_wen_d          = (wb_addr != '0);
                    rf_waddr_d        = wb_addr;
                    rf_wdata_d        = wb_data;
                    busy_d[wb_addr]   = 1'b0;
                end
                // A same-cycle issue to the retiring register wins: newer producer pending
                if (issue_en && (issue_addr != '0)) begin
                    busy_d[issue_addr] = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign wb0_ready = gnt0;
    assign wb1_ready = gnt1;
    assign ra_busy   = busy[ra_addr];
    assign rb_busy   = busy[rb_addr];

`ifdef RF_WB_ARB_PERF_EN
    logic conflict_c;
    logic stall_c;

    assign conflict_c = (state == RUN) && wb0_valid && wb1_valid;
    assign stall_c    = (state == RUN) && ((wb0_valid && !gnt0) || (wb1_valid && !gnt1));

    // Contention counters, free-running with natural wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (conflict_c) conflict_cnt <= conflict_cnt + 32'd1;
            if (stall_c)    stall_cnt    <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized self-checking bench for rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [AW-1:0] wb0_addr, wb1_addr, issue_addr, ra_addr, rb_addr, rf_waddr;
    logic [DW-1:0] wb0_data, wb1_data, rf_wdata;
    logic          issue_en, ra_busy, rb_busy, rf_wen, init_done;
`ifdef RF_WB_ARB_PERF_EN
    logic [31:0]   conflict_cnt, stall_cnt;
    logic [31:0]   conf_m, stall_m;
`endif

    int            checks = 0;
    int            errors = 0;

    // Model state: edges since reset, pending-write set, last winner, expected RF port
    int            edges;
    bit            busy_m [NREG];
    int            rr_m;
    logic          exp_wen;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    bit            known;
    int            last_win;
    logic [AW-1:0] seq [4];

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk         (clk),
        .rstn        (rstn),
        .wb0_valid   (wb0_valid),
        .wb0_ready   (wb0_ready),
        .wb0_addr    (wb0_addr),
        .wb0_data    (wb0_data),
        .wb1_valid   (wb1_valid),
        .wb1_ready   (wb1_ready),
        .wb1_addr    (wb1_addr),
        .wb1_data    (wb1_data),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .ra_addr     (ra_addr),
        .rb_addr     (rb_addr),
        .ra_busy     (ra_busy),
        .rb_busy     (rb_busy),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .init_done   (init_done)
`ifdef RF_WB_ARB_PERF_EN
        ,
        .conflict_cnt(conflict_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        edges     = 0;
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        rr_m      = 1;
        exp_wen   = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        known     = 1'b1;
`ifdef RF_WB_ARB_PERF_EN
        conf_m    = '0;
        stall_m   = '0;
`endif
    endtask

    task automatic check_regs();
        check("rf_wen", 32'(rf_wen), 32'(exp_wen));
        check("init_done", 32'(init_done), 32'(edges >= NREG + 1));
        if (known) begin
            check("rf_waddr", 32'(rf_waddr), 32'(exp_waddr));
            check("rf_wdata", rf_wdata, exp_wdata);
        end
`ifdef RF_WB_ARB_PERF_EN
        check("conflict_cnt", conflict_cnt, conf_m);
        check("stall_cnt", stall_cnt, stall_m);
`endif
    endtask

    // One clock: check combinational outputs, then predict and check the registered ones
    task automatic step();
        int            w;
        bit            run;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        #1;
        run = rstn && (edges >= NREG);
        w   = -1;
        if (run) begin
            if (wb0_valid && wb1_valid) w = (rr_m == 0) ? 1 : 0;
            else if (wb0_valid)         w = 0;
            else if (wb1_valid)         w = 1;
        end
        check("wb0_ready", 32'(wb0_ready), 32'(w == 0));
        check("wb1_ready", 32'(wb1_ready), 32'(w == 1));
        check("ra_busy", 32'(ra_busy), 32'(busy_m[ra_addr]));
        check("rb_busy", 32'(rb_busy), 32'(busy_m[rb_addr]));
        last_win = w;
        @(posedge clk);
        #1;
        if (rstn) begin
            if (!run) begin
                exp_wen   = 1'b1;
                exp_waddr = AW'(edges);
                exp_wdata = '0;
                known     = 1'b1;
            end else begin
`ifdef RF_WB_ARB_PERF_EN
                if (wb0_valid && wb1_valid) conf_m++;
                if ((wb0_valid && w != 0) || (wb1_valid && w != 1)) stall_m++;
`endif
                exp_wen = 1'b0;
                if (w >= 0) begin
                    a         = (w == 1) ? wb1_addr : wb0_addr;
                    d         = (w == 1) ? wb1_data : wb0_data;
                    rr_m      = w;
                    busy_m[a] = 1'b0;
                    if (a != 0) begin
                        exp_wen   = 1'b1;
                        exp_waddr = a;
                        exp_wdata = d;
                        known     = 1'b1;
                    end else begin
                        known = 1'b0;
                    end
                end
                if (issue_en && issue_addr != 0) busy_m[issue_addr] = 1'b1;
            end
            if (edges < 100000) edges++;
        end
        check_regs();
    endtask

    task automatic idle_inputs();
        wb0_valid  = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_valid  = 1'b0; wb1_addr = '0; wb1_data = '0;
        issue_en   = 1'b0; issue_addr = '0;
        ra_addr    = '0;   rb_addr = '0;
    endtask

    task automatic reset_now();
        rstn = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        check("rst_rf_wen", 32'(rf_wen), 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        step();
        rstn = 1'b1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rstn = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check("por_rf_wen", 32'(rf_wen), 32'd0);
        check("por_init_done", 32'(init_done), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Zero-clear sweep
        repeat (NREG) step();
        check("clear_last_addr", 32'(rf_waddr), 32'd31);
        check("clear_last_done", 32'(init_done), 32'd0);
        step();
        check("init_done_rise", 32'(init_done), 32'd1);

        // Held tie: grants alternate starting with requester 0
        wb0_valid = 1'b1; wb0_addr = AW'(3); wb0_data = 32'h3333;
        wb1_valid = 1'b1; wb1_addr = AW'(4); wb1_data = 32'h4444;
        for (int i = 0; i < 4; i++) begin
            step();
            seq[i] = rf_waddr;
        end
        idle_inputs();
        check("tie_seq0", 32'(seq[0]), 32'd3);
        check("tie_seq1", 32'(seq[1]), 32'd4);
        check("tie_seq2", 32'(seq[2]), 32'd3);
        check("tie_seq3", 32'(seq[3]), 32'd4);
`ifdef RF_WB_ARB_PERF_EN
        check("tie_conflicts", conflict_cnt, 32'd4);
        check("tie_stalls", stall_cnt, 32'd4);
`endif

        // Single EXU write
        wb0_valid = 1'b1; wb0_addr = AW'(5); wb0_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        check("single_wen", 32'(rf_wen), 32'd1);
        check("single_waddr", 32'(rf_waddr), 32'd5);
        check("single_wdata", rf_wdata, 32'hDEADBEEF);

        // Scoreboard set, clear, and set-wins collision
        issue_en = 1'b1; issue_addr = AW'(7); ra_addr = AW'(7);
        step();
        issue_en = 1'b0;
        check("sb_set", 32'(ra_busy), 32'd1);
        wb1_valid = 1'b1; wb1_addr = AW'(7); wb1_data = 32'h77;
        step();
        wb1_valid = 1'b0;
        check("sb_clear", 32'(ra_busy), 32'd0);
        issue_en = 1'b1;
        wb1_valid = 1'b1;
        step();
        issue_en = 1'b0;
        wb1_valid = 1'b0;
        check("sb_set_wins", 32'(ra_busy), 32'd1);
        wb1_valid = 1'b1;
        step();
        wb1_valid = 1'b0;

        // Register 0 is never written nor tracked
        wb0_valid = 1'b1; wb0_addr = '0; wb0_data = 32'h1234;
        issue_en = 1'b1; issue_addr = '0; ra_addr = '0;
        step();
        idle_inputs();
        check("x0_wen", 32'(rf_wen), 32'd0);
        check("x0_busy", 32'(ra_busy), 32'd0);

        // Randomized traffic with held requests
        repeat (1500) begin
            if (!wb0_valid && $urandom_range(0, 3) != 0) begin
                wb0_valid = 1'b1; wb0_addr = rand_addr(); wb0_data = $urandom;
            end
            if (!wb1_valid && $urandom_range(0, 3) != 0) begin
                wb1_valid = 1'b1; wb1_addr = rand_addr(); wb1_data = $urandom;
            end
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = rand_addr();
            ra_addr    = rand_addr();
            rb_addr    = rand_addr();
            step();
            if (last_win == 0) wb0_valid = 1'b0;
            if (last_win == 1) wb1_valid = 1'b0;
        end

        // Reset from RUN, then again partway through the clear
        reset_now();
        repeat (10) step();
        check("mid_clear_addr", 32'(rf_waddr), 32'd9);
        reset_now();
        repeat (NREG + 1) step();
        for (int a = 0; a < NREG; a++) begin
            ra_addr = AW'(a);
            rb_addr = AW'(NREG - 1 - a);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
